// File: rtl/arb_defs.sv
// Shared definitions for the instruction/data memory port arbiter.
package arb_defs;

  localparam logic [1:0] ARB_ST_IDLE     = 2'd0;
  localparam logic [1:0] ARB_ST_GNT_INST = 2'd1;
  localparam logic [1:0] ARB_ST_GNT_DATA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = ARB_ST_IDLE,
    ST_GNT_INST = ARB_ST_GNT_INST,
    ST_GNT_DATA = ARB_ST_GNT_DATA
  } arb_state_t;

  localparam int ARB_MAX_STREAK = 4;
  localparam int ARB_TIMEOUT    = 16;

  localparam logic [3:0] ARB_BE_ALL = 4'hF;

endpackage

// File: rtl/arb_pick.sv
// Arbitration decision: data wins unless fetch is waiting and the data streak is exhausted.
module arb_pick (
  input  logic inst_req,
  input  logic data_req,
  input  logic streak_full,
  output logic grant_data
);

  assign grant_data = data_req & (~inst_req | ~streak_full);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, with a
// starvation guard for fetch and a per-transaction timeout.
module mem_port_arbiter
  import arb_defs::*;
#(
  parameter int MAX_STREAK = ARB_MAX_STREAK,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        bus_err,
  output logic        stall_inst,
  output logic        stall_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic [WW-1:0] wait_cnt;
  logic          streak_full;
  logic          grant_data;
  logic          in_grant;
  logic          timed_out;
  logic          done;

  assign streak_full = (streak == SW'(MAX_STREAK));

  arb_pick u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .streak_full (streak_full),
    .grant_data  (grant_data)
  );

  assign in_grant  = (state == ST_GNT_INST) || (state == ST_GNT_DATA);
  // An ack on the last allowed cycle wins over the timeout.
  assign timed_out = in_grant && (wait_cnt == WW'(TIMEOUT - 1)) && !mem_ack;
  assign done      = in_grant && (mem_ack || timed_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      streak   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (!inst_req) streak <= '0;
          if (data_req || inst_req) begin
            if (grant_data) begin
              state <= ST_GNT_DATA;
              if (inst_req && !streak_full) streak <= streak + SW'(1);
            end else begin
              state  <= ST_GNT_INST;
              streak <= '0;
            end
          end
        end
        ST_GNT_INST, ST_GNT_DATA: begin
          if (done) state <= ST_IDLE;
          else      wait_cnt <= wait_cnt + WW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory side follows the granted requester; everything is zero while idle.
  always_comb begin
    mem_en    = in_grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (state == ST_GNT_INST) begin
      mem_addr = inst_addr;
      mem_be   = ARB_BE_ALL;
    end else if (state == ST_GNT_DATA) begin
      mem_we    = data_we;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_be    = data_be;
    end
  end

  always_comb begin
    inst_ready = (state == ST_GNT_INST) && done;
    data_ready = (state == ST_GNT_DATA) && done;
    bus_err    = timed_out;
    inst_rdata = ((state == ST_GNT_INST) && mem_ack) ? mem_rdata : 32'h0;
    data_rdata = ((state == ST_GNT_DATA) && mem_ack) ? mem_rdata : 32'h0;
  end

  assign stall_inst = inst_req & ~inst_ready;
  assign stall_data = data_req & ~data_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, corner sequences, and a random run against a transaction model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_we, mem_ack;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        inst_ready, data_ready, bus_err, stall_inst, stall_data, mem_en, mem_we;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.MAX_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_rdata(data_rdata), .data_ready(data_ready), .bus_err(bus_err),
    .stall_inst(stall_inst), .stall_data(stall_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    inst_req = 0; data_req = 0; mem_ack = 1;
    tick();
    mem_ack = 0;
    tick();
  endtask

  typedef struct {
    logic        ireq, dreq, dwe;
    logic [3:0]  dbe;
    logic        ack;
    logic [31:0] rdata;
    logic        e_en, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    logic        e_ir, e_dr, e_err;
    logic [31:0] e_irdata, e_drdata;
  } vec_t;

  vec_t vec [14];

  // Transaction-level reference: who owns the port, how long, how many data wins in a row.
  int owner, age, run;

  initial begin
    int dgrants;
    bit found;
    int mode;
    logic pi, pd;
    logic        x_en, x_we, x_ir, x_dr, x_err, tmo, dn;
    logic [3:0]  x_be;
    logic [31:0] x_addr, x_wd, x_ird, x_drd;

    rst = 1; inst_req = 0; data_req = 0; data_we = 0; mem_ack = 0;
    inst_addr = 32'h40; data_addr = 32'h100; data_wdata = 32'h55AA; data_be = 0; mem_rdata = 0;
    #12;
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_inst_ready", {31'b0, inst_ready}, 0);
    chk("rst_data_ready", {31'b0, data_ready}, 0);
    chk("rst_bus_err", {31'b0, bus_err}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", {28'b0, mem_be}, 0);
    chk("rst_rdata", inst_rdata | data_rdata, 0);
    @(posedge clk); #1;
    rst = 0;

    vec[0]  = '{1,0,0,4'h0,0,32'h0,        0,0,4'h0,32'h0,  32'h0,   0,0,0,32'h0,32'h0};
    vec[1]  = '{1,0,0,4'h0,0,32'h0,        1,0,4'hF,32'h40, 32'h0,   0,0,0,32'h0,32'h0};
    vec[2]  = '{1,0,0,4'h0,0,32'h0,        1,0,4'hF,32'h40, 32'h0,   0,0,0,32'h0,32'h0};
    vec[3]  = '{1,0,0,4'h0,1,32'h2402000A, 1,0,4'hF,32'h40, 32'h0,   1,0,0,32'h2402000A,32'h0};
    vec[4]  = '{0,0,0,4'h0,0,32'h0,        0,0,4'h0,32'h0,  32'h0,   0,0,0,32'h0,32'h0};
    vec[5]  = '{1,1,1,4'h3,0,32'h0,        0,0,4'h0,32'h0,  32'h0,   0,0,0,32'h0,32'h0};
    vec[6]  = '{1,1,1,4'h3,1,32'h12345678, 1,1,4'h3,32'h100,32'h55AA,0,1,0,32'h0,32'h12345678};
    vec[7]  = '{1,0,0,4'h0,0,32'h0,        0,0,4'h0,32'h0,  32'h0,   0,0,0,32'h0,32'h0};
    vec[8]  = '{1,0,0,4'h0,1,32'hCAFEF00D, 1,0,4'hF,32'h40, 32'h0,   1,0,0,32'hCAFEF00D,32'h0};
    vec[9]  = '{0,0,0,4'h0,1,32'h11111111, 0,0,4'h0,32'h0,  32'h0,   0,0,0,32'h0,32'h0};
    vec[10] = '{0,1,0,4'hF,1,32'h22222222, 0,0,4'h0,32'h0,  32'h0,   0,0,0,32'h0,32'h0};
    vec[11] = '{0,1,0,4'hF,0,32'h0,        1,0,4'hF,32'h100,32'h55AA,0,0,0,32'h0,32'h0};
    vec[12] = '{0,1,0,4'hF,1,32'h0BADC0DE, 1,0,4'hF,32'h100,32'h55AA,0,1,0,32'h0,32'h0BADC0DE};
    vec[13] = '{0,0,0,4'h0,0,32'h0,        0,0,4'h0,32'h0,  32'h0,   0,0,0,32'h0,32'h0};

    for (int i = 0; i < 14; i++) begin
      inst_req = vec[i].ireq; data_req = vec[i].dreq; data_we = vec[i].dwe;
      data_be = vec[i].dbe; mem_ack = vec[i].ack; mem_rdata = vec[i].rdata;
      #1;
      chk($sformatf("v%0d_mem_en", i), {31'b0, mem_en}, {31'b0, vec[i].e_en});
      chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vec[i].e_we});
      chk($sformatf("v%0d_mem_be", i), {28'b0, mem_be}, {28'b0, vec[i].e_be});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vec[i].e_wdata);
      chk($sformatf("v%0d_inst_ready", i), {31'b0, inst_ready}, {31'b0, vec[i].e_ir});
      chk($sformatf("v%0d_data_ready", i), {31'b0, data_ready}, {31'b0, vec[i].e_dr});
      chk($sformatf("v%0d_bus_err", i), {31'b0, bus_err}, {31'b0, vec[i].e_err});
      chk($sformatf("v%0d_inst_rdata", i), inst_rdata, vec[i].e_irdata);
      chk($sformatf("v%0d_data_rdata", i), data_rdata, vec[i].e_drdata);
      chk($sformatf("v%0d_stall_inst", i), {31'b0, stall_inst}, {31'b0, vec[i].ireq & ~vec[i].e_ir});
      chk($sformatf("v%0d_stall_data", i), {31'b0, stall_data}, {31'b0, vec[i].dreq & ~vec[i].e_dr});
      @(posedge clk); #1;
    end

    // Starvation guard: fetch waits through exactly MAXS data grants.
    settle();
    dgrants = 0; found = 0;
    inst_req = 1; data_req = 1; data_we = 0; data_be = 4'hF; mem_ack = 1; mem_rdata = 32'h5;
    for (int c = 0; c < 40 && !found; c++) begin
      #1;
      if (mem_en && mem_addr == 32'h100) dgrants++;
      if (mem_en && mem_addr == 32'h40) begin
        found = 1;
        chk("starve_streak_cleared", 32'(dut.streak), 0);
      end
      @(posedge clk); #1;
    end
    chk("starve_fetch_granted", {31'b0, found}, 1);
    chk("starve_data_grants", dgrants, MAXS);

    // Timeout, then ack/timeout tie.
    for (int t = 0; t < 2; t++) begin
      settle();
      data_req = 1; data_we = 0; mem_ack = 0; mem_rdata = 32'hFFFFFFFF;
      #1;
      chk("tmo_idle_mem_en", {31'b0, mem_en}, 0);
      for (int k = 1; k <= TMO; k++) begin
        @(posedge clk); #1;
        if (k == TMO && t == 1) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
        #1;
        if (k < TMO) begin
          if (k == 1 || k == TMO - 1)
            chk($sformatf("tmo%0d_early_ready_c%0d", t, k), {30'b0, data_ready, bus_err}, 0);
        end else begin
          chk($sformatf("tmo%0d_data_ready", t), {31'b0, data_ready}, 1);
          chk($sformatf("tmo%0d_bus_err", t), {31'b0, bus_err}, (t == 0) ? 32'd1 : 32'd0);
          chk($sformatf("tmo%0d_data_rdata", t), data_rdata, (t == 0) ? 32'h0 : 32'hDEADBEEF);
        end
      end
      @(posedge clk); #1;
      data_req = 0; mem_ack = 0;
      #1;
      chk($sformatf("tmo%0d_mem_en_after", t), {31'b0, mem_en}, 0);
    end

    // Async reset mid-grant, regrant, then an illegal request drop.
    settle();
    data_req = 1; data_we = 1; data_be = 4'h3; mem_ack = 0;
    tick();
    #1;
    chk("arst_granted", {31'b0, mem_en}, 1);
    rst = 1; mem_ack = 1;
    #1;
    chk("arst_mem_en_drop", {31'b0, mem_en}, 0);
    chk("arst_no_ready", {30'b0, data_ready, inst_ready}, 0);
    mem_ack = 0;
    #1;
    rst = 0;
    @(posedge clk); #1;
    chk("arst_regrant_en", {31'b0, mem_en}, 1);
    chk("arst_regrant_addr", mem_addr, 32'h100);
    data_req = 0;
    tick();
    #1;
    chk("drop_no_ready_yet", {31'b0, data_ready}, 0);
    chk("drop_still_granted", {31'b0, mem_en}, 1);
    mem_ack = 1; mem_rdata = 32'h77;
    #1;
    chk("drop_ready_pulse", {31'b0, data_ready}, 1);
    chk("drop_stall_data", {31'b0, stall_data}, 0);

    // Random run against the reference model.
    settle();
    owner = 0; age = 0; run = 0; pi = 0; pd = 0;
    for (int blk = 0; blk < 3; blk++) begin
      mode = blk;
      for (int c = 0; c < 250; c++) begin
        if (!inst_req) begin
          inst_req = ($urandom_range(0, 2) != 0); inst_addr = $urandom;
        end else if (pi) begin
          inst_req = $urandom_range(0, 1); inst_addr = $urandom;
        end
        if (!data_req || pd) begin
          data_req = data_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) != 0);
          data_addr = $urandom; data_wdata = $urandom; data_we = $urandom_range(0, 1);
          data_be = 4'($urandom_range(0, 15));
        end
        mem_ack = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 2);
        mem_rdata = $urandom;
        #1;
        x_en = (owner != 0); x_we = 0; x_be = 0; x_addr = 0; x_wd = 0;
        tmo = (owner != 0) && (age == TMO - 1) && !mem_ack;
        dn = (owner != 0) && (mem_ack || tmo);
        x_ir = (owner == 1) && dn; x_dr = (owner == 2) && dn; x_err = tmo;
        x_ird = (owner == 1 && mem_ack) ? mem_rdata : 0;
        x_drd = (owner == 2 && mem_ack) ? mem_rdata : 0;
        if (owner == 1) begin x_addr = inst_addr; x_be = 4'hF; end
        if (owner == 2) begin x_addr = data_addr; x_we = data_we; x_wd = data_wdata; x_be = data_be; end
        chk("rnd_mem_en", {31'b0, mem_en}, {31'b0, x_en});
        chk("rnd_mem_we", {31'b0, mem_we}, {31'b0, x_we});
        chk("rnd_mem_be", {28'b0, mem_be}, {28'b0, x_be});
        chk("rnd_mem_addr", mem_addr, x_addr);
        chk("rnd_mem_wdata", mem_wdata, x_wd);
        chk("rnd_ready", {30'b0, inst_ready, data_ready}, {30'b0, x_ir, x_dr});
        chk("rnd_bus_err", {31'b0, bus_err}, {31'b0, x_err});
        chk("rnd_inst_rdata", inst_rdata, x_ird);
        chk("rnd_data_rdata", data_rdata, x_drd);
        chk("rnd_stall", {30'b0, stall_inst, stall_data}, {30'b0, inst_req & ~x_ir, data_req & ~x_dr});
        pi = x_ir; pd = x_dr;
        if (owner == 0) begin
          if (!inst_req) run = 0;
          if (data_req && (!inst_req || run < MAXS)) begin
            owner = 2; age = 0;
            if (inst_req && run < MAXS) run++;
          end else if (inst_req) begin
            owner = 1; age = 0; run = 0;
          end
        end else if (dn) begin
          owner = 0;
        end else begin
          age++;
        end
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
